// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with fill count,
// almost-full / almost-empty thresholds, sticky overflow / underflow flags
// and a selectable standard or first-word-fall-through read port.

module sync_fifo_param #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 4,
   parameter bit FWFT          = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AFULL_CNT  = AFULL_THRESH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = AEMPTY_THRESH[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH:0] wr_ptr;
   logic [ADDR_WIDTH:0] rd_ptr;
   logic [ADDR_WIDTH:0] count_q;

   logic wr_accept;
   logic rd_accept;

   // The pointer MSBs only carry wrap parity; the fill level comes from
   // count_q, so they are collected here to keep them visible without use.
   logic unused_ptr_msb;

   assign unused_ptr_msb = wr_ptr[ADDR_WIDTH] ^ rd_ptr[ADDR_WIDTH];

   // Acceptance looks only at the registered flags, so a write while full
   // is refused even if a read drains a slot on the same edge (and vice
   // versa for a read while empty).
   assign wr_accept = wr_en && !full;
   assign rd_accept = rd_en && !empty;

   // Status flags decode straight from the registered count.
   assign count        = count_q;
   assign full         = (count_q == DEPTH_CNT);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AFULL_CNT);
   assign almost_empty = (count_q <= AEMPTY_CNT);

   // Storage array: written on every accepted write, never reset.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
      end
   end

   // Write and read pointers advance on acceptance and wrap mod 2*DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_accept) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Fill count: up on a lone write, down on a lone read, else unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         case ({wr_accept, rd_accept})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky error flags; a set condition on the same edge as clr_err wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end

   generate
      if (FWFT) begin : g_fwft
         // Head word is presented combinationally from the registered
         // read pointer; rd_en merely acknowledges it.
         assign data_out = mem[rd_ptr[ADDR_WIDTH-1:0]];
      end else begin : g_std
         // Registered read port: loads the head word on an accepted read
         // and holds through idle cycles and rejected reads.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_out <= '0;
            end else if (rd_accept) begin
               data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: drives a standard-mode and an FWFT-mode FIFO with the
// same directed stimulus and compares both against a queue-based model.

module tb_sync_fifo_param;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [7:0] data_in;
   logic       rd_en;
   logic       clr_err;

   logic [7:0] dout_std;
   logic       full_std, empty_std, afull_std, aempty_std;
   logic [4:0] count_std;
   logic       ovf_std, udf_std;

   logic [7:0] dout_fw;
   logic       full_fw, empty_fw, afull_fw, aempty_fw;
   logic [4:0] count_fw;
   logic       ovf_fw, udf_fw;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] model_q [$];
   logic [7:0] exp_dout;
   logic       exp_ovf;
   logic       exp_udf;

   sync_fifo_param #(.FWFT(1'b0)) dut_std (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .data_in      (data_in),
      .rd_en        (rd_en),
      .data_out     (dout_std),
      .full         (full_std),
      .empty        (empty_std),
      .almost_full  (afull_std),
      .almost_empty (aempty_std),
      .count        (count_std),
      .overflow     (ovf_std),
      .underflow    (udf_std),
      .clr_err      (clr_err)
   );

   sync_fifo_param #(.FWFT(1'b1)) dut_fw (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .data_in      (data_in),
      .rd_en        (rd_en),
      .data_out     (dout_fw),
      .full         (full_fw),
      .empty        (empty_fw),
      .almost_full  (afull_fw),
      .almost_empty (aempty_fw),
      .count        (count_fw),
      .overflow     (ovf_fw),
      .underflow    (udf_fw),
      .clr_err      (clr_err)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      model_q.delete();
      exp_dout = 8'h00;
      exp_ovf  = 1'b0;
      exp_udf  = 1'b0;
   endtask

   // Compare every status output of both instances against the model.
   task automatic check_all(input string tag);
      int sz;
      sz = model_q.size();
      check_output({tag, " count_std"},  32'(count_std),  32'(sz));
      check_output({tag, " count_fw"},   32'(count_fw),   32'(sz));
      check_output({tag, " empty"},      32'(empty_std),  32'(sz == 0));
      check_output({tag, " full"},       32'(full_std),   32'(sz == 16));
      check_output({tag, " afull"},      32'(afull_std),  32'(sz >= 12));
      check_output({tag, " aempty"},     32'(aempty_std), 32'(sz <= 4));
      check_output({tag, " empty_fw"},   32'(empty_fw),   32'(sz == 0));
      check_output({tag, " ovf"},        32'(ovf_std),    32'(exp_ovf));
      check_output({tag, " udf"},        32'(udf_std),    32'(exp_udf));
      check_output({tag, " ovf_fw"},     32'(ovf_fw),     32'(exp_ovf));
      check_output({tag, " udf_fw"},     32'(udf_fw),     32'(exp_udf));
      check_output({tag, " dout_std"},   32'(dout_std),   32'(exp_dout));
      if (sz > 0) begin
         check_output({tag, " dout_fw"}, 32'(dout_fw),    32'(model_q[0]));
      end
   endtask

   // One clock cycle of stimulus: drive, predict, clock, then check.
   task automatic apply_stimulus(input string tag, input logic w, input logic [7:0] d,
                                 input logic r, input logic c);
      logic wa, ra;
      wr_en   = w;
      data_in = d;
      rd_en   = r;
      clr_err = c;
      wa = w && (model_q.size() < 16);
      ra = r && (model_q.size() > 0);
      if (c) begin
         exp_ovf = 1'b0;
         exp_udf = 1'b0;
      end
      if (w && model_q.size() == 16) exp_ovf = 1'b1;
      if (r && model_q.size() == 0)  exp_udf = 1'b1;
      @(posedge clk);
      if (ra) exp_dout = model_q.pop_front();
      if (wa) model_q.push_back(d);
      #1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      check_all(tag);
   endtask

   initial begin
      logic [7:0] next_data;

      rst     = 1'b1;
      wr_en   = 1'b0;
      data_in = 8'h00;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      check_output("reset aempty const", 32'(aempty_std), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Fill with 0x01..0x10, then one rejected write.
      for (int i = 1; i <= 16; i++) begin
         apply_stimulus("fill", 1'b1, 8'(i), 1'b0, 1'b0);
         if (i == 11) check_output("afull before 12", 32'(afull_std), 32'd0);
         if (i == 12) check_output("afull at 12", 32'(afull_std), 32'd1);
      end
      check_output("full at 16", 32'(full_std), 32'd1);
      apply_stimulus("overflow write", 1'b1, 8'hAA, 1'b0, 1'b0);
      check_output("ovf const", 32'(ovf_std), 32'd1);
      check_output("count stays 16", 32'(count_std), 32'd16);

      // Drain all 16 words, then one rejected read.
      for (int i = 1; i <= 16; i++) begin
         apply_stimulus("drain", 1'b0, 8'h00, 1'b1, 1'b0);
         check_output("drain seq", 32'(dout_std), 32'(i));
      end
      apply_stimulus("underflow read", 1'b0, 8'h00, 1'b1, 1'b0);
      check_output("dout holds 0x10", 32'(dout_std), 32'h10);
      apply_stimulus("clr_err", 1'b0, 8'h00, 1'b0, 1'b1);

      // Simultaneous write+read at empty, then clr_err interplay.
      apply_stimulus("wr+rd at empty", 1'b1, 8'h77, 1'b1, 1'b0);
      check_output("wr+rd count 1", 32'(count_std), 32'd1);
      apply_stimulus("clr udf", 1'b0, 8'h00, 1'b0, 1'b1);
      apply_stimulus("drain 0x77", 1'b0, 8'h00, 1'b1, 1'b0);
      apply_stimulus("clr+rd empty", 1'b0, 8'h00, 1'b1, 1'b1);
      check_output("set beats clear", 32'(udf_std), 32'd1);
      apply_stimulus("clr again", 1'b0, 8'h00, 1'b0, 1'b1);

      // Sustained read/write at count=8, pointers wrap past 2*DEPTH.
      next_data = 8'h80;
      for (int i = 0; i < 8; i++) begin
         apply_stimulus("prefill 8", 1'b1, next_data, 1'b0, 1'b0);
         next_data++;
      end
      for (int i = 0; i < 40; i++) begin
         apply_stimulus("stream", 1'b1, next_data, 1'b1, 1'b0);
         check_output("stream delay 8", 32'(dout_std), 32'(8'(next_data - 8'd8)));
         next_data++;
      end
      for (int i = 0; i < 8; i++) begin
         apply_stimulus("post-stream drain", 1'b0, 8'h00, 1'b1, 1'b0);
      end

      // FWFT fall-through of a single word into an empty FIFO.
      apply_stimulus("fwft write 5A", 1'b1, 8'h5A, 1'b0, 1'b0);
      check_output("fwft head 5A", 32'(dout_fw), 32'h5A);
      apply_stimulus("fwft idle", 1'b0, 8'h00, 1'b0, 1'b0);
      apply_stimulus("fwft pop", 1'b0, 8'h00, 1'b1, 1'b0);
      check_output("fwft empty after pop", 32'(empty_fw), 32'd1);
      apply_stimulus("udf before reset", 1'b0, 8'h00, 1'b1, 1'b0);

      // Fill to 9, then reset asynchronously in the middle of a write burst.
      for (int i = 0; i < 9; i++) begin
         apply_stimulus("burst", 1'b1, 8'(8'h40 + 8'(i)), 1'b0, 1'b0);
      end
      wr_en   = 1'b1;
      data_in = 8'h4F;
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async reset");
      check_output("async reset dout", 32'(dout_std), 32'd0);
      wr_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      apply_stimulus("post-reset write 33", 1'b1, 8'h33, 1'b0, 1'b0);
      apply_stimulus("post-reset read 33", 1'b0, 8'h00, 1'b1, 1'b0);
      check_output("post-reset dout 33", 32'(dout_std), 32'h33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
